instr_encode_loader: RTL and testbench

- Inverse of the control decoder: turns symbolic instruction requests (kind plus fields) into 32-bit MIPS machine words.
- Writes each word into instruction memory at consecutive word addresses.
- Used by the bring-up path and testbenches to build programs on-chip for the single-cycle datapath.
- Covers the decoder's instruction subset; rejects anything else.

---
 rtl/instr_encode_loader_if.sv | 46 ++++
 rtl/instr_encode_loader.sv | 155 +++++++++++++++
 tb/tb_instr_encode_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_loader_if.sv
// Bundle between a program-building master and the instruction encoder/loader:
// symbolic request channel, load control, instruction-memory write channel and status.
interface instr_encode_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;

    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;

    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              im_ack;

    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [4:0]        err_kind;

    modport master (
        output start, base_addr,
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        input  in_ready,
        input  im_we, im_addr, im_wdata,
        output im_ack,
        input  count, full, err, err_kind
    );

    modport slave (
        input  start, base_addr,
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        output in_ready,
        output im_we, im_addr, im_wdata,
        input  im_ack,
        output count, full, err, err_kind
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes symbolic MIPS instruction requests into 32-bit words and writes them
// to instruction memory at consecutive word addresses, one word per cycle at best.
module instr_encode_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_encode_loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [31:0]       wdata_reg;
    logic              we_reg;
    logic [ADDR_W:0]   count_reg;
    logic              err_reg;
    logic [4:0]        err_kind_reg;

    logic              enc_legal;
    logic [31:0]       enc_word;
    logic              ack_fire;
    logic              last_addr;
    logic              in_ready_w;
    logic              accept;
    logic              legal_accept;
    logic              illegal_accept;
    logic [ADDR_W-1:0] addr_next;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {6'h00, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'h0000_0000;
        case (bus.in_kind)
            5'd0:  enc_word = enc_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21);
            5'd1:  enc_word = enc_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h23);
            5'd2:  enc_word = enc_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20);
            5'd3:  enc_word = enc_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22);
            5'd4:  enc_word = enc_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24);
            5'd5:  enc_word = enc_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25);
            5'd6:  enc_word = enc_r(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A);
            // Shifts take their operand from rt; rs is not part of the encoding.
            5'd7:  enc_word = enc_r(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00);
            5'd8:  enc_word = enc_r(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h02);
            5'd9:  enc_word = enc_i(6'h0D, bus.in_rs, bus.in_rt, bus.in_imm);
            5'd10: enc_word = enc_i(6'h23, bus.in_rs, bus.in_rt, bus.in_imm);
            5'd11: enc_word = enc_i(6'h2B, bus.in_rs, bus.in_rt, bus.in_imm);
            5'd12: enc_word = enc_i(6'h04, bus.in_rs, bus.in_rt, bus.in_imm);
            5'd13: enc_word = enc_i(6'h05, bus.in_rs, bus.in_rt, bus.in_imm);
            5'd14: enc_word = enc_i(6'h0A, bus.in_rs, bus.in_rt, bus.in_imm);
            5'd15: enc_word = enc_i(6'h0F, 5'd0, bus.in_rt, bus.in_imm);
            5'd16: enc_word = {6'h02, bus.in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    assign addr_next = addr_reg + ADDR_W'(1);
    assign last_addr = (&addr_reg) || (addr_next == base_reg);
    assign ack_fire  = (state_reg == ST_PEND) && bus.im_ack;

    // Ready is withheld on the final address so nothing is accepted that could never be written.
    assign in_ready_w = rst_n && !bus.start &&
                        ((state_reg == ST_IDLE) || (ack_fire && !last_addr));
    assign accept         = bus.in_valid && in_ready_w;
    assign legal_accept   = accept && enc_legal;
    assign illegal_accept = accept && !enc_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            base_reg     <= '0;
            wdata_reg    <= 32'h0000_0000;
            we_reg       <= 1'b0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            err_kind_reg <= 5'd0;
        end else if (bus.start) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= bus.base_addr;
            base_reg     <= bus.base_addr;
            we_reg       <= 1'b0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            err_kind_reg <= 5'd0;
        end else begin
            if (illegal_accept && !err_reg) begin
                err_reg      <= 1'b1;
                err_kind_reg <= bus.in_kind;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (legal_accept) begin
                        wdata_reg <= enc_word;
                        we_reg    <= 1'b1;
                        state_reg <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (ack_fire) begin
                        if (count_reg != COUNT_MAX) begin
                            count_reg <= count_reg + (ADDR_W + 1)'(1);
                        end
                        if (last_addr) begin
                            state_reg <= ST_FULL;
                            we_reg    <= 1'b0;
                        end else begin
                            addr_reg <= addr_next;
                            // Back-to-back: the next word replaces the acked one without a bubble.
                            if (legal_accept) begin
                                wdata_reg <= enc_word;
                            end else begin
                                we_reg    <= 1'b0;
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    we_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    we_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_w;
    assign bus.im_we    = we_reg;
    assign bus.im_addr  = addr_reg;
    assign bus.im_wdata = wdata_reg;
    assign bus.count    = count_reg;
    assign bus.full     = (state_reg == ST_FULL);
    assign bus.err      = err_reg;
    assign bus.err_kind = err_kind_reg;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed and randomized checks of instr_encode_loader; a 10-bit and a 2-bit
// address instance share one clock and reset.
module tb_instr_encode_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encode_loader_if #(.ADDR_W(10)) a ();
    instr_encode_loader_if #(.ADDR_W(2))  b ();

    instr_encode_loader #(.ADDR_W(10)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
    instr_encode_loader #(.ADDR_W(2))  u_b (.clk(clk), .rst_n(rst_n), .bus(b));

    int total = 0;
    int bad   = 0;

    // Reference model state for the randomized phase
    bit            mon_en = 1'b0;
    logic [63:0]   exp_q[$];
    int unsigned   mbase;
    int unsigned   npushed;
    int            commits;
    bit            merr;
    logic [4:0]    mkind;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic bit ref_legal(input int k);
        return (k >= 0) && (k <= 16);
    endfunction

    // Encoding rebuilt from the field positions with shifts and opcode tables.
    function automatic logic [31:0] ref_word(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] sh,
                                             input logic [15:0] imm, input logic [25:0] tgt);
        int unsigned f_tab [9];
        int unsigned o_tab [7];
        int unsigned w;
        int unsigned rsv;
        f_tab = '{32'h21, 32'h23, 32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h00, 32'h02};
        o_tab = '{32'h0D, 32'h23, 32'h2B, 32'h04, 32'h05, 32'h0A, 32'h0F};
        w = 0;
        if (k <= 6)
            w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | f_tab[k];
        else if (k <= 8)
            w = (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | f_tab[k];
        else if (k <= 15) begin
            rsv = (k == 15) ? 0 : 32'(rs);
            w = (o_tab[k-9] << 26) | (rsv << 21) | (32'(rt) << 16) | 32'(imm);
        end else if (k == 16)
            w = (32'd2 << 26) | 32'(tgt);
        return w;
    endfunction

    task automatic drive_a(input int k, input int rs, input int rt, input int rd,
                           input int sh, input int imm, input int tgt);
        a.in_valid  = 1'b1;
        a.in_kind   = 5'(k);
        a.in_rs     = 5'(rs);
        a.in_rt     = 5'(rt);
        a.in_rd     = 5'(rd);
        a.in_shamt  = 5'(sh);
        a.in_imm    = 16'(imm);
        a.in_target = 26'(tgt);
    endtask

    // Scoreboard for the randomized phase: predicted writes in acceptance order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a.im_we && a.im_ack) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_write", 64'(a.im_addr), 64'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    $display("wr addr=%0h data=%08h", a.im_addr, a.im_wdata);
                    check("rnd_addr", 64'(a.im_addr), 64'(e[63:32]));
                    check("rnd_data", 64'(a.im_wdata), 64'(e[31:0]));
                    commits++;
                end
            end
            if (a.in_valid && a.in_ready) begin
                if (ref_legal(int'(a.in_kind))) begin
                    exp_q.push_back({32'((mbase + npushed) % 1024),
                                     ref_word(int'(a.in_kind), a.in_rs, a.in_rt, a.in_rd,
                                              a.in_shamt, a.in_imm, a.in_target)});
                    npushed++;
                end else if (!merr) begin
                    merr  = 1'b1;
                    mkind = a.in_kind;
                end
            end
        end
    end

    int          s_kind [4] = '{10, 15, 7, 16};
    int          s_rs   [4] = '{29, 7, 9, 0};
    int          s_rt   [4] = '{8, 1, 3, 0};
    int          s_rd   [4] = '{0, 0, 2, 0};
    int          s_sh   [4] = '{0, 0, 4, 0};
    int          s_imm  [4] = '{4, 32'h1234, 0, 0};
    int          s_tgt  [4] = '{0, 0, 0, 32'h0100000};
    logic [31:0] s_exp  [4] = '{32'h8FA80004, 32'h3C011234, 32'h00031100, 32'h08100000};

    initial begin
        a.start = 0; a.base_addr = '0; a.in_valid = 0; a.in_kind = 0; a.in_rs = 0; a.in_rt = 0;
        a.in_rd = 0; a.in_shamt = 0; a.in_imm = 0; a.in_target = 0; a.im_ack = 0;
        b.start = 0; b.base_addr = '0; b.in_valid = 0; b.in_kind = 0; b.in_rs = 0; b.in_rt = 0;
        b.in_rd = 0; b.in_shamt = 0; b.in_imm = 0; b.in_target = 0; b.im_ack = 0;

        // Reset state
        tick(); tick(); settle();
        check("rst_we", 64'(a.im_we), 64'd0);
        check("rst_addr", 64'(a.im_addr), 64'd0);
        check("rst_wdata", 64'(a.im_wdata), 64'd0);
        check("rst_count", 64'(a.count), 64'd0);
        check("rst_full", 64'(a.full), 64'd0);
        check("rst_err", 64'(a.err), 64'd0);
        check("rst_err_kind", 64'(a.err_kind), 64'd0);
        check("rst_ready", 64'(a.in_ready), 64'd0);
        tick(); rst_n = 1'b1;

        // Single addu, one-cycle latency
        tick(); a.start = 1; a.base_addr = '0; settle();
        check("start_ready", 64'(a.in_ready), 64'd0);
        tick(); a.start = 0; drive_a(0, 1, 2, 3, 0, 0, 0); a.im_ack = 1; settle();
        check("idle_ready", 64'(a.in_ready), 64'd1);
        tick(); a.in_valid = 0; settle();
        check("addu_we", 64'(a.im_we), 64'd1);
        check("addu_addr", 64'(a.im_addr), 64'd0);
        check("addu_data", 64'(a.im_wdata), 64'h00221821);
        tick(); settle();
        check("addu_count", 64'(a.count), 64'd1);
        check("addu_we_drop", 64'(a.im_we), 64'd0);

        // Back-to-back stream from address 0
        tick(); a.start = 1; a.base_addr = '0;
        tick(); a.start = 0; drive_a(s_kind[0], s_rs[0], s_rt[0], s_rd[0], s_sh[0], s_imm[0], s_tgt[0]);
        settle();
        check("stream_ready0", 64'(a.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) drive_a(s_kind[i+1], s_rs[i+1], s_rt[i+1], s_rd[i+1], s_sh[i+1], s_imm[i+1], s_tgt[i+1]);
            else a.in_valid = 0;
            settle();
            check("stream_we", 64'(a.im_we), 64'd1);
            check("stream_addr", 64'(a.im_addr), 64'(i));
            check("stream_data", 64'(a.im_wdata), 64'(s_exp[i]));
            if (i < 3) check("stream_ready", 64'(a.in_ready), 64'd1);
        end
        tick(); settle();
        check("stream_count", 64'(a.count), 64'd4);
        check("stream_idle_we", 64'(a.im_we), 64'd0);

        // Stall in PEND with im_ack low
        tick(); drive_a(5, 3, 4, 5, 0, 0, 0); a.im_ack = 0;
        tick(); a.in_valid = 0; settle();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick(); settle(); end
            check("stall_we", 64'(a.im_we), 64'd1);
            check("stall_addr", 64'(a.im_addr), 64'd4);
            check("stall_data", 64'(a.im_wdata), 64'h00642825);
            check("stall_ready", 64'(a.in_ready), 64'd0);
            check("stall_count", 64'(a.count), 64'd4);
        end
        tick(); a.im_ack = 1; settle();
        check("stall_ack_ready", 64'(a.in_ready), 64'd1);
        tick(); settle();
        check("stall_addr_inc", 64'(a.im_addr), 64'd5);
        check("stall_count_inc", 64'(a.count), 64'd5);

        // Illegal kinds: sticky err, first kind captured
        tick(); drive_a(20, 0, 0, 0, 0, 0, 0); settle();
        check("ill_ready", 64'(a.in_ready), 64'd1);
        tick(); a.in_kind = 5'd25; settle();
        check("ill_we", 64'(a.im_we), 64'd0);
        check("ill_err", 64'(a.err), 64'd1);
        check("ill_kind", 64'(a.err_kind), 64'd20);
        tick(); drive_a(9, 2, 6, 0, 0, 32'hBEEF, 0); settle();
        check("ill2_we", 64'(a.im_we), 64'd0);
        check("ill2_kind", 64'(a.err_kind), 64'd20);
        tick(); a.in_valid = 0; settle();
        check("ori_we", 64'(a.im_we), 64'd1);
        check("ori_addr", 64'(a.im_addr), 64'd5);
        check("ori_data", 64'(a.im_wdata), 64'h3446BEEF);
        tick(); settle();
        check("ori_count", 64'(a.count), 64'd6);
        check("ori_err_sticky", 64'(a.err), 64'd1);

        // Small memory fills up
        tick(); b.start = 1; b.base_addr = '0;
        tick(); b.start = 0; b.in_valid = 1; b.in_kind = 5'd9; b.in_rs = 5'd1; b.in_rt = 5'd2;
        b.in_imm = 16'd0; b.im_ack = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); b.in_imm = 16'(i + 1); settle();
            check("fill_we", 64'(b.im_we), 64'd1);
            check("fill_addr", 64'(b.im_addr), 64'(i));
            check("fill_data", 64'(b.im_wdata), 64'(32'h34220000 | 32'(i)));
        end
        tick(); settle();
        check("fill_full", 64'(b.full), 64'd1);
        check("fill_count", 64'(b.count), 64'd4);
        check("fill_ready", 64'(b.in_ready), 64'd0);
        check("fill_we_off", 64'(b.im_we), 64'd0);
        tick(); settle();
        check("fill_stall_ready", 64'(b.in_ready), 64'd0);
        check("fill_stall_we", 64'(b.im_we), 64'd0);
        tick(); b.start = 1; b.in_valid = 0;
        tick(); b.start = 0; settle();
        check("restart_full", 64'(b.full), 64'd0);
        check("restart_count", 64'(b.count), 64'd0);
        check("restart_ready", 64'(b.in_ready), 64'd1);

        // Reset in the middle of a pending write
        tick(); drive_a(1, 0, 0, 0, 0, 0, 0); a.im_ack = 0;
        tick(); a.in_valid = 0; settle();
        check("mid_we", 64'(a.im_we), 64'd1);
        rst_n = 1'b0; #1;
        check("mid_rst_we", 64'(a.im_we), 64'd0);
        check("mid_rst_count", 64'(a.count), 64'd0);
        check("mid_rst_ready", 64'(a.in_ready), 64'd0);
        tick(); tick(); rst_n = 1'b1;
        tick(); drive_a(2, 4, 5, 6, 0, 0, 0); a.im_ack = 1;
        tick(); a.in_valid = 0; settle();
        check("post_rst_we", 64'(a.im_we), 64'd1);
        check("post_rst_addr", 64'(a.im_addr), 64'd0);
        check("post_rst_data", 64'(a.im_wdata), 64'h00853020);
        tick(); settle();
        check("post_rst_count", 64'(a.count), 64'd1);

        // Randomized traffic against the reference model
        tick(); a.start = 1; a.base_addr = 10'($urandom_range(0, 511));
        mbase = 32'(a.base_addr); npushed = 0; commits = 0; merr = 0; mkind = 0; exp_q.delete();
        tick(); a.start = 0; mon_en = 1;
        for (int i = 0; i < 300; i++) begin
            int k;
            k = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, 16)) : int'($urandom_range(17, 31));
            drive_a(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 32'h3FFFFFF)));
            a.in_valid = ($urandom_range(0, 99) < 70);
            a.im_ack   = ($urandom_range(0, 99) < 60);
            tick();
        end
        a.in_valid = 0; a.im_ack = 1;
        for (int i = 0; i < 4; i++) tick();
        mon_en = 0;
        settle();
        check("rnd_drained", 64'(exp_q.size()), 64'd0);
        check("rnd_count", 64'(a.count), 64'(commits));
        check("rnd_err", 64'(a.err), 64'(merr));
        if (merr) check("rnd_err_kind", 64'(a.err_kind), 64'(mkind));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
